// File: rtl/wb_burst_ram.sv
// Wishbone B3 on-chip RAM slave with byte-enabled writes and
// registered-feedback constant, incrementing and wrapping bursts.
module wb_burst_ram #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int DEPTH   = 8192,
  parameter     MEMFILE = ""
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  output logic [DW-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o
);

  localparam int SB = $clog2(DW / 8);
  localparam int WB = $clog2(DEPTH);

  localparam logic [2:0] CTI_CONST = 3'b001;
  localparam logic [2:0] CTI_INCR  = 3'b010;

  typedef enum logic {IDLE, BURST} bst_t;

  bst_t            bst, bst_nxt;
  logic [WB-1:0]   ptr, ptr_nxt;
  logic            ack_nxt, err_nxt;
  logic [DW-1:0]   mem [DEPTH];

  logic [WB-1:0]   adr_idx;
  logic            oor;
  logic            burst_cti;
  logic            accept;
  logic            hit;
  logic [WB-1:0]   tgt;
  logic            mem_we;
  logic            mem_rd;
  logic            unused_lsb;

  function automatic logic [WB-1:0] next_idx(input logic [WB-1:0] i,
                                             input logic [2:0]    cti,
                                             input logic [1:0]    bte);
    logic [WB-1:0] n;
    n = i;
    if (cti != CTI_CONST) begin
      case (bte)
        2'b00:   n      = i + WB'(1);
        2'b01:   n[1:0] = i[1:0] + 2'd1;
        2'b10:   n[2:0] = i[2:0] + 3'd1;
        default: n[3:0] = i[3:0] + 4'd1;
      endcase
    end
    return n;
  endfunction

  // Sub-word address bits carry no meaning for a word-wide slave.
  if (SB > 0) begin : g_lsb
    assign unused_lsb = ^wb_adr_i[SB-1:0];
  end else begin : g_nolsb
    assign unused_lsb = 1'b0;
  end

  assign adr_idx   = wb_adr_i[SB+WB-1:SB];
  assign oor       = |wb_adr_i[AW-1:SB+WB];
  assign burst_cti = (wb_cti_i == CTI_CONST) || (wb_cti_i == CTI_INCR);

  // A held strobe is only re-accepted inside a burst; a pending err blocks it.
  assign accept = wb_cyc_i & wb_stb_i & ~wb_err_o & (~wb_ack_o | (bst == BURST));
  assign tgt    = (bst == BURST) ? ptr : adr_idx;
  assign hit    = accept & ((bst == BURST) | ~oor);

  // Reset gating keeps an edge that coincides with reset from writing.
  assign mem_we = hit & wb_we_i & ~wb_rst_i;
  assign mem_rd = hit & ~wb_we_i;

  always_comb begin
    bst_nxt = IDLE;
    ptr_nxt = ptr;
    ack_nxt = 1'b0;
    err_nxt = 1'b0;
    if (hit) begin
      ack_nxt = 1'b1;
      if (burst_cti) begin
        bst_nxt = BURST;
      end
      if ((bst == BURST) || burst_cti) begin
        ptr_nxt = next_idx(tgt, wb_cti_i, wb_bte_i);
      end
    end else if (accept) begin
      err_nxt = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      bst <= IDLE;
    end else begin
      bst <= bst_nxt;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ptr      <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      ptr      <= ptr_nxt;
      wb_ack_o <= ack_nxt;
      wb_err_o <= err_nxt;
      if (mem_rd) begin
        wb_dat_o <= mem[tgt];
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < DW / 8; b++) begin
        if (wb_sel_i[b]) begin
          mem[tgt][8*b +: 8] <= wb_dat_i[8*b +: 8];
        end
      end
    end
  end

endmodule
